apb_cmd_master: RTL

//  Synthesizable APB3 initiator. Drives the myuart register port (CR/THR/RHR/SR/BRGR/IMR) from a simple command stream.

---
 rtl/apb_cmd_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// APB3 initiator that replays a buffered command stream as SETUP/ACCESS
// transfers and returns one response per command, in command order.
module apb_cmd_master #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_write_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Last counter value before an ACCESS with no pready is abandoned
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready_o = !full;
    assign push        = cmd_valid_i && !full;
    assign pop         = (state == S_IDLE) && !empty;
    assign head        = mem[rd_ptr[PTR_W-1:0]];
    assign busy_o      = (state != S_IDLE) || !empty;

    // Command storage; contents are don't-care until written, so no reset
    always_ff @(posedge pclk_i) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i};
        end
    end

    // FIFO pointers; natural wrap of the extended pointers
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_write_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        {pwrite_o, paddr_o, pwdata_o} <= head;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_o <= 1'b1;
                    cnt       <= '0;
                    state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        rsp_err_o   <= pslverr_i;
                        rsp_rdata_o <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                        rsp_write_o <= pwrite_o;
                        rsp_valid_o <= 1'b1;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        state       <= S_RESP;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_write_o <= pwrite_o;
                        rsp_valid_o <= 1'b1;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
